tpu_seq_ctrl: RTL and testbench
===============================

Name: tpu_seq_ctrl

Overview:
Command sequencer that drives the tpuv1 control inputs (opcode, idx, hl) and the operand-data select on behalf of the host.
- Accepts one command at a time over a valid/ready handshake: LOADA row, LOADB, CLEAR, RUN.
- Expands each command into the correct cycle-by-cycle tpuv1 opcode sequence.
- For RUN, steps the systolic array the full wavefront length, then streams all C rows out as half-row beats under res_valid/res_ready backpressure.

Parameters:
- DIM, 8, systolic array dimension; rows of A and C.
- STEPS, 3*DIM-2, systolic_step cycles issued per RUN.
- ROWW, 4, width of the idx/row field; must satisfy 2**ROWW >= DIM.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  controller can accept a command (high only in IDLE).
- cmd_op  in  2  command: 0=LOADA, 1=LOADB, 2=CLEAR, 3=RUN.
- cmd_row  in  ROWW  A row for LOADA; ignored otherwise.
- tpu_opcode  out  3  opcode to tpuv1.
- tpu_idx  out  ROWW  idx to tpuv1.
- tpu_hl  out  1  hl to tpuv1.
- data_zero  out  1  1 = external mux drives v_high/v_low to zero; 0 = host data.
- res_valid  out  1  tpuv1 data_out holds a valid C half-row.
- res_ready  in  1  consumer accepts the current beat.
- res_row  out  ROWW  C row of the current beat.
- res_hl  out  1  half of the current beat (0 = columns 0-3, 1 = columns 4-7).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last beat of RUN or the last write of CLEAR.

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-low.
  - All outputs are registered.
  - Reset values: state IDLE, tpu_opcode=nop(0), tpu_idx=0, tpu_hl=0, data_zero=0, res_valid=0, res_row=0, res_hl=0, busy=0, done=0, all counters 0.
  - Reset asserted mid-command aborts it: next cycle is IDLE with opcode nop, and no done pulse is issued.
- Command acceptance:
  - A command is accepted on cycle T when cmd_valid && cmd_ready.
  - The first issued opcode appears at T+1.
  - cmd_ready = (state==IDLE) and drops at T+1.
- States: IDLE, LOADA, LOADB, CLEAR, STEP, DRAIN, DONE.
- IDLE: opcode nop; wait for a command.
- LOADA: one cycle with opcode writeA(1), idx=cmd_row captured at T, data_zero=0. Then DONE-free return to IDLE (no done pulse).
- LOADB: one cycle with opcode writeB(2), data_zero=0. Then IDLE (no done). The host presents the next B column at the same cycle.
- CLEAR:
  - 2*DIM cycles of opcode writeC(3) with data_zero=1.
  - idx/hl walk (0,0),(0,1),(1,0),…,(DIM-1,1).
  - Then DONE.
- STEP:
  - STEPS consecutive cycles of opcode systolic_step(6), data_zero=1, idx=0.
  - Step counter runs 0..STEPS-1, then DRAIN.
- DRAIN:
  - opcode readC(5), res_valid=1, tpu_idx=res_row, tpu_hl=res_hl.
  - A beat completes on res_valid && res_ready. Then advance: hl 0→1, or hl 1→0 with row+1.
  - With res_ready low, opcode, idx and hl hold unchanged indefinitely.
  - After beat (DIM-1,1) is accepted, go to DONE; res_valid falls the same edge.
- DONE: one cycle with done=1, opcode nop, then IDLE. cmd_ready stays 0 during DONE.
- Row counters are ROWW bits and wrap only through reset to 0; no wrap beyond DIM-1 is ever issued.
- cmd_op/cmd_row are ignored while cmd_ready=0.
- res_ready while res_valid=0 has no effect.
- Total RUN latency with res_ready tied high: acceptance T, STEP T+1..T+STEPS, DRAIN 2*DIM cycles, done at T+STEPS+2*DIM+1, IDLE at T+STEPS+2*DIM+2.

Decomposition:
- Shared package tpu_pkg holds:
  - The opcode enum: nop=0, writeA=1, writeB=2, writeC=3, matmul=4, readC=5, systolic_step=6 (3-bit), shared with tpuv1.
  - The cmd_op enum (LOADA/LOADB/CLEAR/RUN).
  - The state typedef.
- Single module; the row/hl walk counter (used by CLEAR and DRAIN) is natural as sub-module tpu_rowhl_cnt (inputs: clear, advance; outputs: row, hl, last).

Test Plan:
- Reset mid-RUN: assert rst_n=0 at step 10 → next cycle opcode=0, busy=0, cmd_ready=1, done never pulses.
- LOADA row 5 at T → T+1 opcode=1, idx=5, data_zero=0; T+2 opcode=0, cmd_ready=1, done=0.
- CLEAR → 16 cycles opcode=3, data_zero=1, (idx,hl) sequence 0/0…7/1, done pulse at T+17, cmd_ready=1 at T+18.
- RUN with res_ready=1 → 22 cycles opcode=6, then 16 readC beats rows 0..7 × hl 0,1, done at T+39; with identity A and B=k loaded, the beats carry the expected C values.
- RUN with res_ready low for 5 cycles on beat (3,1) → opcode=5, idx=3, hl=1 held for 5 cycles, no beat skipped or duplicated, total beats=16.
- Back-to-back: cmd_valid held high with RUN during busy → no second acceptance until IDLE; second RUN accepted exactly at T+40.

Source files
------------

// File: rtl/tpu_pkg.sv
// ============================================================================
// tpu_pkg : opcodes, host commands and sequencer states shared with tpuv1
// Rev 1.0
// ============================================================================
`default_nettype none

package tpu_pkg;

   typedef enum logic [2:0] {
      OP_NOP     = 3'd0,
      OP_WRITEA  = 3'd1,
      OP_WRITEB  = 3'd2,
      OP_WRITEC  = 3'd3,
      OP_MATMUL  = 3'd4,
      OP_READC   = 3'd5,
      OP_STEP    = 3'd6
   } opcode_e;

   typedef enum logic [1:0] {
      CMD_LOADA = 2'd0,
      CMD_LOADB = 2'd1,
      CMD_CLEAR = 2'd2,
      CMD_RUN   = 2'd3
   } cmd_op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOADA = 3'd1,
      S_LOADB = 3'd2,
      S_CLEAR = 3'd3,
      S_STEP  = 3'd4,
      S_DRAIN = 3'd5,
      S_DONE  = 3'd6
   } state_e;

   function automatic opcode_e state_opcode(input state_e s);
      opcode_e op;
      unique case (s)
         S_LOADA: op = OP_WRITEA;
         S_LOADB: op = OP_WRITEB;
         S_CLEAR: op = OP_WRITEC;
         S_STEP:  op = OP_STEP;
         S_DRAIN: op = OP_READC;
         default: op = OP_NOP;
      endcase
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tpu_rowhl_cnt.sv
// ============================================================================
// tpu_rowhl_cnt : (row, half) walker used by CLEAR writes and DRAIN beats
// Rev 1.0
// ============================================================================
`default_nettype none

module tpu_rowhl_cnt
   import tpu_pkg::*;
#(
   parameter int DIM  = 8,
   parameter int ROWW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_clear,
   input  logic            i_advance,
   output logic [ROWW-1:0] o_row,
   output logic            o_hl,
   output logic            o_last
);

   logic [ROWW-1:0] r_row;
   logic            r_hl;

   // o_row/o_hl give the position after this cycle's clear/advance, so the
   // parent can register it straight onto tpu_idx/tpu_hl.
   assign o_last = (r_row == ROWW'(DIM - 1)) && r_hl;

   always_comb begin
      o_row = r_row;
      o_hl  = r_hl;
      if (i_clear || (i_advance && o_last)) begin
         o_row = '0;
         o_hl  = 1'b0;
      end else if (i_advance) begin
         if (r_hl) begin
            o_row = r_row + ROWW'(1);
            o_hl  = 1'b0;
         end else begin
            o_hl  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_row <= '0;
         r_hl  <= 1'b0;
      end else begin
         r_row <= o_row;
         r_hl  <= o_hl;
      end
   end

endmodule

`default_nettype wire

// File: rtl/tpu_seq_ctrl.sv
// ============================================================================
// tpu_seq_ctrl : expands host commands into cycle-by-cycle tpuv1 opcodes
// Rev 1.0
// ============================================================================
`default_nettype none

module tpu_seq_ctrl
   import tpu_pkg::*;
#(
   parameter int DIM   = 8,
   parameter int STEPS = 3*DIM - 2,
   parameter int ROWW  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [ROWW-1:0] cmd_row,
   output logic [2:0]      tpu_opcode,
   output logic [ROWW-1:0] tpu_idx,
   output logic            tpu_hl,
   output logic            data_zero,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [ROWW-1:0] res_row,
   output logic            res_hl,
   output logic            busy,
   output logic            done
);

   localparam int STEP_W = $clog2(STEPS + 1);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [STEP_W-1:0]  r_step;
   logic               w_accept;
   logic               w_advance;
   logic [ROWW-1:0]    w_row_nxt;
   logic               w_hl_nxt;
   logic               w_last;
   logic [ROWW-1:0]    w_idx_nxt;
   logic               w_tpu_hl_nxt;

   logic               r_cmd_ready;
   logic [2:0]         r_opcode;
   logic [ROWW-1:0]    r_idx;
   logic               r_hl;
   logic               r_data_zero;
   logic               r_res_valid;
   logic [ROWW-1:0]    r_res_row;
   logic               r_res_hl;
   logic               r_busy;
   logic               r_done;

   assign w_accept  = (r_state == S_IDLE) && cmd_valid;
   assign w_advance = (r_state == S_CLEAR) || ((r_state == S_DRAIN) && res_ready);

   tpu_rowhl_cnt #(
      .DIM  (DIM),
      .ROWW (ROWW)
   ) u_rowhl (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_accept),
      .i_advance (w_advance),
      .o_row     (w_row_nxt),
      .o_hl      (w_hl_nxt),
      .o_last    (w_last)
   );

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op_e'(cmd_op))
                  CMD_LOADA: w_state_nxt = S_LOADA;
                  CMD_LOADB: w_state_nxt = S_LOADB;
                  CMD_CLEAR: w_state_nxt = S_CLEAR;
                  CMD_RUN:   w_state_nxt = S_STEP;
               endcase
            end
         end
         S_LOADA, S_LOADB: w_state_nxt = S_IDLE;
         S_CLEAR: if (w_last) w_state_nxt = S_DONE;
         S_STEP:  if (r_step == STEP_W'(STEPS - 1)) w_state_nxt = S_DRAIN;
         S_DRAIN: if (res_ready && w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output registers are loaded from the next state so every port is a flop.
   always_comb begin
      w_idx_nxt    = '0;
      w_tpu_hl_nxt = 1'b0;
      if (w_state_nxt == S_LOADA) begin
         w_idx_nxt = cmd_row;
      end else if ((w_state_nxt == S_CLEAR) || (w_state_nxt == S_DRAIN)) begin
         w_idx_nxt    = w_row_nxt;
         w_tpu_hl_nxt = w_hl_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_step      <= '0;
         r_cmd_ready <= 1'b1;
         r_opcode    <= OP_NOP;
         r_idx       <= '0;
         r_hl        <= 1'b0;
         r_data_zero <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_row   <= '0;
         r_res_hl    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_step      <= ((r_state == S_STEP) && (w_state_nxt == S_STEP)) ?
                        r_step + STEP_W'(1) : '0;
         r_cmd_ready <= (w_state_nxt == S_IDLE);
         r_opcode    <= state_opcode(w_state_nxt);
         r_idx       <= w_idx_nxt;
         r_hl        <= w_tpu_hl_nxt;
         r_data_zero <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_STEP);
         r_res_valid <= (w_state_nxt == S_DRAIN);
         r_res_row   <= w_row_nxt;
         r_res_hl    <= w_hl_nxt;
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_DONE);
      end
   end

   assign cmd_ready  = r_cmd_ready;
   assign tpu_opcode = r_opcode;
   assign tpu_idx    = r_idx;
   assign tpu_hl     = r_hl;
   assign data_zero  = r_data_zero;
   assign res_valid  = r_res_valid;
   assign res_row    = r_res_row;
   assign res_hl     = r_res_hl;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tpu_seq_ctrl.sv
// ============================================================================
// tb_tpu_seq_ctrl : scoreboard bench for the tpuv1 command sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tpu_seq_ctrl;

   localparam int DIM   = 8;
   localparam int STEPS = 3*DIM - 2;
   localparam int ROWW  = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cmd_valid = 1'b0;
   logic [1:0]      cmd_op = '0;
   logic [ROWW-1:0] cmd_row = '0;
   logic            res_ready = 1'b1;
   logic            cmd_ready;
   logic [2:0]      tpu_opcode;
   logic [ROWW-1:0] tpu_idx;
   logic            tpu_hl;
   logic            data_zero;
   logic            res_valid;
   logic [ROWW-1:0] res_row;
   logic            res_hl;
   logic            busy;
   logic            done;

   tpu_seq_ctrl #(.DIM(DIM), .STEPS(STEPS), .ROWW(ROWW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_row(cmd_row), .tpu_opcode(tpu_opcode),
      .tpu_idx(tpu_idx), .tpu_hl(tpu_hl), .data_zero(data_zero),
      .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
      .res_hl(res_hl), .busy(busy), .done(done)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [2:0]      op;
      logic [ROWW-1:0] idx;
      logic            hl;
      logic            dz;
      bit              is_done;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0, errors = 0;
   int  cyc = 0, done_cyc = 0, done_seen = 0;
   int  beats = 0, stall31 = 0, hold_n = 0, rdy_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push_ev(logic [2:0] op, logic [ROWW-1:0] idx,
                                   logic hl, logic dz, bit d);
      ev_t e;
      e.op = op; e.idx = idx; e.hl = hl; e.dz = dz; e.is_done = d;
      exp_q.push_back(e);
   endfunction

   // Reference: each command becomes its list of non-nop tpuv1 cycles and done.
   function automatic void model(logic [1:0] op, logic [ROWW-1:0] row);
      case (op)
         2'd0: push_ev(3'd1, row, 1'b0, 1'b0, 1'b0);
         2'd1: push_ev(3'd2, '0, 1'b0, 1'b0, 1'b0);
         2'd2: begin
            for (int r = 0; r < DIM; r++)
               for (int h = 0; h < 2; h++) push_ev(3'd3, ROWW'(r), 1'(h), 1'b1, 1'b0);
            push_ev(3'd0, '0, 1'b0, 1'b0, 1'b1);
         end
         default: begin
            for (int s = 0; s < STEPS; s++) push_ev(3'd6, '0, 1'b0, 1'b1, 1'b0);
            for (int r = 0; r < DIM; r++)
               for (int h = 0; h < 2; h++) push_ev(3'd5, ROWW'(r), 1'(h), 1'b0, 1'b0);
            push_ev(3'd0, '0, 1'b0, 1'b0, 1'b1);
         end
      endcase
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Monitor: pops one expected event per issued opcode / completed beat / done.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (cmd_ready == busy) begin
            errors++;
            $display("FAIL ready_busy: cmd_ready=%0d busy=%0d", cmd_ready, busy);
         end
         if (done || tpu_opcode != 3'd0 || res_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected: op=%0d done=%0d with empty queue", tpu_opcode, done);
            end else begin
               ev_t e;
               bit  ok;
               e = exp_q[0];
               if (done)
                  ok = e.is_done && tpu_opcode == 3'd0 && !res_valid;
               else
                  ok = !e.is_done && tpu_opcode == e.op && tpu_idx == e.idx &&
                       tpu_hl == e.hl && data_zero == e.dz &&
                       res_valid == (e.op == 3'd5) &&
                       (e.op != 3'd5 || (res_row == e.idx && res_hl == e.hl));
               if (!ok) begin
                  errors++;
                  $display("FAIL op_seq: got op=%0d idx=%0d hl=%0d dz=%0d rv=%0d done=%0d exp op=%0d idx=%0d hl=%0d dz=%0d done=%0d",
                           tpu_opcode, tpu_idx, tpu_hl, data_zero, res_valid, done,
                           e.op, e.idx, e.hl, e.dz, e.is_done);
               end
               if (done) begin
                  done_cyc = cyc;
                  done_seen++;
               end
               if (tpu_opcode == 3'd5 && !res_ready) begin
                  if (tpu_idx == ROWW'(3) && tpu_hl) stall31++;
               end else begin
                  if (tpu_opcode == 3'd5) beats++;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // Consumer: 0 = always ready, 1 = random, 2 = stall beat (3,1) five cycles.
   initial forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
         0: res_ready = 1'b1;
         1: res_ready = 1'($urandom_range(0, 1));
         default: begin
            if (res_valid && res_row == ROWW'(3) && res_hl && hold_n < 5) begin
               res_ready = 1'b0;
               hold_n++;
            end else begin
               res_ready = 1'b1;
            end
         end
      endcase
   end

   task automatic issue(input logic [1:0] op, input logic [ROWW-1:0] row,
                        input bit keep, output int t_acc);
      int n = 0;
      @(posedge clk);
      #2;
      cmd_valid = 1'b1; cmd_op = op; cmd_row = row;
      @(negedge clk);
      while (!cmd_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", int'(n >= 1000), 0);
      t_acc = cyc;
      model(op, row);
      if (!keep) begin
         @(posedge clk);
         #2;
         cmd_valid = 1'b0;
         cmd_op = 2'($urandom);
         cmd_row = ROWW'($urandom);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(cmd_ready && exp_q.size() == 0) && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", int'(n >= 600), 0);
   endtask

   initial begin
      int t, t2, ds;
      logic [1:0] rop;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_opcode", int'(tpu_opcode), 0);
      chk("reset_outs", int'({tpu_idx, tpu_hl, data_zero, res_valid, res_row, res_hl, busy, done}), 0);
      chk("reset_ready", int'(cmd_ready), 1);
      @(posedge clk);
      #2 rst_n = 1'b1;

      issue(2'd0, ROWW'(5), 1'b0, t);
      wait_idle();
      issue(2'd1, '0, 1'b0, t);
      wait_idle();

      issue(2'd2, '0, 1'b0, t);
      wait_idle();
      chk("clear_done_latency", done_cyc - t, 2*DIM + 1);

      beats = 0;
      issue(2'd3, '0, 1'b0, t);
      wait_idle();
      chk("run_done_latency", done_cyc - t, STEPS + 2*DIM + 1);
      chk("run_beats", beats, 2*DIM);

      rdy_mode = 2; hold_n = 0; stall31 = 0; beats = 0;
      issue(2'd3, '0, 1'b0, t);
      wait_idle();
      chk("stall_31_cycles", stall31, 5);
      chk("stall_beats", beats, 2*DIM);
      rdy_mode = 0;

      issue(2'd3, '0, 1'b1, t);
      issue(2'd3, '0, 1'b0, t2);
      chk("b2b_accept", t2 - t, STEPS + 2*DIM + 2);
      wait_idle();

      rdy_mode = 1;
      for (int i = 0; i < 20; i++) begin
         rop = 2'($urandom_range(0, 3));
         beats = 0;
         issue(rop, ROWW'($urandom_range(0, DIM - 1)), 1'b0, t);
         wait_idle();
         if (rop == 2'd3) chk("rand_run_beats", beats, 2*DIM);
      end

      rdy_mode = 0;
      issue(2'd3, '0, 1'b0, t);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #1 exp_q.delete();
      ds = done_seen;
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_opcode", int'(tpu_opcode), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_ready", int'(cmd_ready), 1);
      repeat (30) @(negedge clk);
      chk("abort_no_done", done_seen, ds);
      chk("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
